// File: rtl/div8su4_seq.sv
// Sequential 8-bit signed by 4-bit unsigned divider, truncating toward zero.
// Restoring division on the dividend magnitude, then one sign-fix cycle.
module div8su4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [4:0] remainder,
  output logic       div_by_zero
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [DW-1:0] mag;
  logic          neg;
  logic [VW-1:0] dvs;
  logic [RW-1:0] pr;
  logic [DW-1:0] q;
  logic [CW-1:0] cnt;

  logic [RW-1:0] pr_shift;
  logic          pr_ge;
  logic [RW-1:0] pr_next;
  logic [DW-1:0] dividend_mag;

  // One restoring step: pr < dvs <= 15 keeps the shifted value within 5 bits.
  always_comb begin
    pr_shift     = {pr[RW-2:0], mag[DW-1]};
    pr_ge        = (pr_shift >= RW'(dvs));
    pr_next      = pr_ge ? (pr_shift - RW'(dvs)) : pr_shift;
    dividend_mag = dividend[DW-1] ? DW'(-dividend) : dividend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      mag         <= '0;
      neg         <= 1'b0;
      dvs         <= '0;
      pr          <= '0;
      q           <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              mag         <= dividend_mag;
              neg         <= dividend[DW-1];
              dvs         <= divisor;
              pr          <= '0;
              q           <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end

        CALC: begin
          pr  <= pr_next;
          q   <= {q[DW-2:0], pr_ge};
          mag <= {mag[DW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) state <= FIX;
        end

        // Magnitude 128 with neg set maps back to 8'h80; positive side never reaches 128.
        FIX: begin
          quotient  <= neg ? DW'(-q) : q;
          remainder <= neg ? RW'(-pr) : pr;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8su4_seq.sv
// Directed self-checking bench for div8su4_seq.
module tb_div8su4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  div8su4_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Runs one op from IDLE (called #1 after an edge), captures the result, consumes it.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [4:0] r,
                       output logic z, output int lat);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 8'h5A; divisor = 4'h0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 5'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h z=%b required 1 0 00 00 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    do_op(8'h64, 4'd7, q, r, z, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d required 9", lat); end
    checks++;
    if ({q, r, z} !== {8'h0E, 5'h02, 1'b0}) begin
      errors++; $display("FAIL basic_100_7: q=%h r=%h z=%b required 0e 02 0", q, r, z);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_consume: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_negative();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    do_op(8'h9C, 4'd7, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'hF2, 5'h1E, 1'b0}) begin
      errors++; $display("FAIL neg_m100_7: q=%h r=%h z=%b required f2 1e 0", q, r, z);
    end
    do_op(8'h80, 4'd1, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h80, 5'h00, 1'b0}) begin
      errors++; $display("FAIL neg_m128_1: q=%h r=%h z=%b required 80 00 0", q, r, z);
    end
    do_op(8'h00, 4'd5, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h00, 5'h00, 1'b0}) begin
      errors++; $display("FAIL zero_dividend: q=%h r=%h z=%b required 00 00 0", q, r, z);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    do_op(8'h05, 4'd0, q, r, z, lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d required 0", lat); end
    checks++;
    if ({q, r, z} !== {8'h00, 5'h00, 1'b1}) begin
      errors++; $display("FAIL dz_result: q=%h r=%h z=%b required 00 00 1", q, r, z);
    end
    do_op(8'h0F, 4'd3, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h05, 5'h00, 1'b0}) begin
      errors++; $display("FAIL dz_next_op: q=%h r=%h z=%b required 05 00 0", q, r, z);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    in_valid = 1'b1; dividend = 8'd20; divisor = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b1; dividend = 8'h33; divisor = 4'd2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h06, 5'h02, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b q=%h r=%h z=%b required 1 0 06 02 0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    do_op(8'h33, 4'd2, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'h19, 5'h01, 1'b0} || lat !== 9) begin
      errors++; $display("FAIL bp_new_op: q=%h r=%h z=%b lat=%0d required 19 01 0 9", q, r, z, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    in_valid = 1'b1; dividend = 8'd90; divisor = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 5'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b q=%h r=%h z=%b required 1 0 00 00 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    do_op(8'hCE, 4'd6, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {8'hF8, 5'h1E, 1'b0}) begin
      errors++; $display("FAIL reset_mid_next: q=%h r=%h z=%b required f8 1e 0", q, r, z);
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    for (int s = -8; s <= 7; s++) begin
      for (int u = 1; u <= 15; u++) begin
        do_op(8'(s * u), 4'(u), q, r, z, lat);
        checks++;
        if ({q, r, z} !== {8'(s), 5'h00, 1'b0}) begin
          errors++;
          $display("FAIL round_trip s=%0d u=%0d: q=%h r=%h z=%b required %h 00 0", s, u, q, r, z, 8'(s));
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] q; logic [4:0] r; logic z; int lat;
    logic signed [7:0] a8;
    int a, eq, er, gq, gr;
    for (int d = 0; d < 256; d++) begin
      for (int u = 1; u <= 15; u++) begin
        a8 = 8'(d);
        a  = int'(a8);
        eq = a / u;
        er = a % u;
        do_op(8'(d), 4'(u), q, r, z, lat);
        gq = int'($signed(q));
        gr = int'($signed(r));
        checks++;
        if ({q, r, z} !== {8'(eq), 5'(er), 1'b0} || gq * u + gr != a) begin
          errors++;
          $display("FAIL sweep a=%0d u=%0d: q=%0d r=%0d z=%b required %0d %0d 0", a, u, gq, gr, z, eq, er);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = 8'h00; divisor = 4'h0;
    test_reset();
    test_basic();
    test_negative();
    test_div_zero();
    test_back_pressure();
    test_reset_mid();
    test_round_trip();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
